// File: rtl/procyon_lsu_sq_launch.sv
// Store-queue retire launcher: round-robin pick of one retirable SQ entry per cycle, in-order update routing.
// Latency: retire pulse combinational, LSU launch registered (+1 cycle), update routing combinational.
// Backpressure: no launch while i_lsu_stall, i_flush or the in-flight tracker is full (full evaluated pre-pop).
// Optional: define PCYN_SQ_LAUNCH_PERF_CNT_EN to add saturating launch/relaunch performance counters.

`ifndef PCYN_OP_WIDTH
`define PCYN_OP_WIDTH 4
`endif

module procyon_lsu_sq_launch #(
    parameter int OPTN_SQ_DEPTH      = 8,
    parameter int OPTN_DATA_WIDTH    = 32,
    parameter int OPTN_ADDR_WIDTH    = 32,
    parameter int OPTN_ROB_IDX_WIDTH = 5,
    parameter int OPTN_MAX_INFLIGHT  = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          i_flush,
    input  logic [OPTN_SQ_DEPTH-1:0]                      i_sq_retirable,
    input  logic [OPTN_SQ_DEPTH*`PCYN_OP_WIDTH-1:0]       i_sq_op,
    input  logic [OPTN_SQ_DEPTH*OPTN_ROB_IDX_WIDTH-1:0]   i_sq_tag,
    input  logic [OPTN_SQ_DEPTH*OPTN_ADDR_WIDTH-1:0]      i_sq_addr,
    input  logic [OPTN_SQ_DEPTH*OPTN_DATA_WIDTH-1:0]      i_sq_data,
    output logic [OPTN_SQ_DEPTH-1:0]                      o_sq_retire_en,
    input  logic                                          i_lsu_stall,
    output logic                                          o_lsu_retire_en,
    output logic [`PCYN_OP_WIDTH-1:0]                     o_lsu_retire_op,
    output logic [OPTN_ROB_IDX_WIDTH-1:0]                 o_lsu_retire_tag,
    output logic [OPTN_ADDR_WIDTH-1:0]                    o_lsu_retire_addr,
    output logic [OPTN_DATA_WIDTH-1:0]                    o_lsu_retire_data,
    input  logic                                          i_lsu_update_en,
    input  logic                                          i_lsu_update_retry,
    input  logic                                          i_lsu_update_replay,
    input  logic                                          i_lsu_update_mhq_retry,
    input  logic                                          i_lsu_update_mhq_replay,
    output logic [OPTN_SQ_DEPTH-1:0]                      o_sq_update_en,
    output logic                                          o_sq_update_retry,
    output logic                                          o_sq_update_replay,
    output logic                                          o_sq_update_mhq_retry,
    output logic                                          o_sq_update_mhq_replay,
    output logic                                          o_inflight_full
`ifdef PCYN_SQ_LAUNCH_PERF_CNT_EN
    ,
    output logic [31:0]                                   o_perf_launch_cnt,
    output logic [31:0]                                   o_perf_relaunch_cnt
`endif
);

    localparam int IDX_W = $clog2(OPTN_SQ_DEPTH);
    localparam int PTR_W = (OPTN_MAX_INFLIGHT > 1) ? $clog2(OPTN_MAX_INFLIGHT) : 1;
    localparam int CNT_W = $clog2(OPTN_MAX_INFLIGHT + 1);
    localparam int OP_W  = `PCYN_OP_WIDTH;

    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_sel;
    logic             w_launch;
    logic             w_pop;
    logic             w_empty;

    // In-flight tracker: ring of launched entry indices, oldest at r_head.
    logic [IDX_W-1:0] r_fifo [0:OPTN_MAX_INFLIGHT-1];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OPTN_MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_inflight_full = (r_count == CNT_W'(OPTN_MAX_INFLIGHT));
    assign w_empty         = (r_count == '0);
    assign w_launch        = (|i_sq_retirable) & ~i_lsu_stall & ~o_inflight_full & ~i_flush;
    assign w_pop           = i_lsu_update_en & ~w_empty & ~i_flush;

    // Round-robin search: first retirable entry at or after r_rr_ptr, wrapping.
    always_comb begin : sel_blk
        logic             found;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        w_sel = r_rr_ptr;
        for (int i = 0; i < OPTN_SQ_DEPTH; i++) begin
            idx = r_rr_ptr + IDX_W'(i);
            if (!found && i_sq_retirable[idx]) begin
                w_sel = idx;
                found = 1'b1;
            end
        end
    end

    // One-hot retire pulse to the selected entry, only in launch cycles.
    always_comb begin
        o_sq_retire_en = '0;
        if (w_launch) o_sq_retire_en[w_sel] = 1'b1;
    end

    // One-hot update enable to the oldest launched entry; flags are broadcast.
    always_comb begin
        o_sq_update_en = '0;
        if (w_pop) o_sq_update_en[r_fifo[r_head]] = 1'b1;
    end

    assign o_sq_update_retry      = i_lsu_update_retry;
    assign o_sq_update_replay     = i_lsu_update_replay;
    assign o_sq_update_mhq_retry  = i_lsu_update_mhq_retry;
    assign o_sq_update_mhq_replay = i_lsu_update_mhq_replay;

    // Round-robin pointer advances past the launched entry; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst)           r_rr_ptr <= '0;
        else if (w_launch) r_rr_ptr <= w_sel + 1'b1;
    end

    // Tracker pointers/count; flush drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_launch) r_tail <= ptr_inc(r_tail);
            if (w_pop)    r_head <= ptr_inc(r_head);
            case ({w_launch, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Tracker storage; slot contents are only meaningful below r_count.
    always_ff @(posedge clk) begin
        if (w_launch) r_fifo[r_tail] <= w_sel;
    end

    // Registered launch to the LSU, capturing the entry fields of the pulse cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_lsu_retire_en   <= 1'b0;
            o_lsu_retire_op   <= '0;
            o_lsu_retire_tag  <= '0;
            o_lsu_retire_addr <= '0;
            o_lsu_retire_data <= '0;
        end else begin
            o_lsu_retire_en <= w_launch;
            if (w_launch) begin
                o_lsu_retire_op   <= i_sq_op[w_sel*OP_W +: OP_W];
                o_lsu_retire_tag  <= i_sq_tag[w_sel*OPTN_ROB_IDX_WIDTH +: OPTN_ROB_IDX_WIDTH];
                o_lsu_retire_addr <= i_sq_addr[w_sel*OPTN_ADDR_WIDTH +: OPTN_ADDR_WIDTH];
                o_lsu_retire_data <= i_sq_data[w_sel*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH];
            end
        end
    end

`ifdef PCYN_SQ_LAUNCH_PERF_CNT_EN
    logic w_relaunch;
    assign w_relaunch = w_pop & (i_lsu_update_retry | i_lsu_update_replay |
                                 i_lsu_update_mhq_retry | i_lsu_update_mhq_replay);

    // Saturating performance counters; survive flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_perf_launch_cnt   <= '0;
            o_perf_relaunch_cnt <= '0;
        end else begin
            if (w_launch && (o_perf_launch_cnt != '1))     o_perf_launch_cnt   <= o_perf_launch_cnt + 1'b1;
            if (w_relaunch && (o_perf_relaunch_cnt != '1)) o_perf_relaunch_cnt <= o_perf_relaunch_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_procyon_lsu_sq_launch.sv
// Bench for procyon_lsu_sq_launch: directed cycles with launch/update scoreboards.
// Expected launches and updates are queued when stimulus is driven and popped when the DUT produces them.
// Combinational pulses are checked directly each cycle on the falling edge.

`ifndef PCYN_OP_WIDTH
`define PCYN_OP_WIDTH 4
`endif

module tb_procyon_lsu_sq_launch;

    localparam int D  = 8;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int OW = `PCYN_OP_WIDTH;

    typedef struct packed {
        logic [7:0] oh;
        logic [3:0] fl;   // {retry, replay, mhq_retry, mhq_replay}
    } upd_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               i_flush = 1'b0;
    logic [D-1:0]       i_sq_retirable = '0;
    logic [D*OW-1:0]    i_sq_op;
    logic [D*RW-1:0]    i_sq_tag;
    logic [D*AW-1:0]    i_sq_addr;
    logic [D*DW-1:0]    i_sq_data;
    logic [D-1:0]       o_sq_retire_en;
    logic               i_lsu_stall = 1'b0;
    logic               o_lsu_retire_en;
    logic [OW-1:0]      o_lsu_retire_op;
    logic [RW-1:0]      o_lsu_retire_tag;
    logic [AW-1:0]      o_lsu_retire_addr;
    logic [DW-1:0]      o_lsu_retire_data;
    logic               i_lsu_update_en = 1'b0;
    logic               i_lsu_update_retry = 1'b0;
    logic               i_lsu_update_replay = 1'b0;
    logic               i_lsu_update_mhq_retry = 1'b0;
    logic               i_lsu_update_mhq_replay = 1'b0;
    logic [D-1:0]       o_sq_update_en;
    logic               o_sq_update_retry;
    logic               o_sq_update_replay;
    logic               o_sq_update_mhq_retry;
    logic               o_sq_update_mhq_replay;
    logic               o_inflight_full;
`ifdef PCYN_SQ_LAUNCH_PERF_CNT_EN
    logic [31:0]        o_perf_launch_cnt;
    logic [31:0]        o_perf_relaunch_cnt;
`endif

    logic [AW-1:0] ent_addr [D];
    logic [DW-1:0] ent_data [D];
    logic [RW-1:0] ent_tag  [D];
    logic [OW-1:0] ent_op   [D];

    int   launch_q [$];
    upd_t upd_q    [$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    procyon_lsu_sq_launch #(
        .OPTN_SQ_DEPTH(D), .OPTN_DATA_WIDTH(DW), .OPTN_ADDR_WIDTH(AW),
        .OPTN_ROB_IDX_WIDTH(RW), .OPTN_MAX_INFLIGHT(4)
    ) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush),
        .i_sq_retirable(i_sq_retirable), .i_sq_op(i_sq_op), .i_sq_tag(i_sq_tag),
        .i_sq_addr(i_sq_addr), .i_sq_data(i_sq_data), .o_sq_retire_en(o_sq_retire_en),
        .i_lsu_stall(i_lsu_stall), .o_lsu_retire_en(o_lsu_retire_en),
        .o_lsu_retire_op(o_lsu_retire_op), .o_lsu_retire_tag(o_lsu_retire_tag),
        .o_lsu_retire_addr(o_lsu_retire_addr), .o_lsu_retire_data(o_lsu_retire_data),
        .i_lsu_update_en(i_lsu_update_en), .i_lsu_update_retry(i_lsu_update_retry),
        .i_lsu_update_replay(i_lsu_update_replay), .i_lsu_update_mhq_retry(i_lsu_update_mhq_retry),
        .i_lsu_update_mhq_replay(i_lsu_update_mhq_replay), .o_sq_update_en(o_sq_update_en),
        .o_sq_update_retry(o_sq_update_retry), .o_sq_update_replay(o_sq_update_replay),
        .o_sq_update_mhq_retry(o_sq_update_mhq_retry), .o_sq_update_mhq_replay(o_sq_update_mhq_replay),
        .o_inflight_full(o_inflight_full)
`ifdef PCYN_SQ_LAUNCH_PERF_CNT_EN
        , .o_perf_launch_cnt(o_perf_launch_cnt), .o_perf_relaunch_cnt(o_perf_relaunch_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Launch / update scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin : mon
        int   k;
        upd_t u;
        if (o_lsu_retire_en === 1'b1) begin
            if (launch_q.size() == 0) begin
                chk("spurious_launch", 1, 0);
            end else begin
                k = launch_q.pop_front();
                chk("launch_addr", 64'(o_lsu_retire_addr), 64'(ent_addr[k]));
                chk("launch_data", 64'(o_lsu_retire_data), 64'(ent_data[k]));
                chk("launch_tag",  64'(o_lsu_retire_tag),  64'(ent_tag[k]));
                chk("launch_op",   64'(o_lsu_retire_op),   64'(ent_op[k]));
            end
        end
        if ((|o_sq_update_en) === 1'b1) begin
            if (upd_q.size() == 0) begin
                chk("spurious_update", 64'(o_sq_update_en), 0);
            end else begin
                u = upd_q.pop_front();
                chk("update_en", 64'(o_sq_update_en), 64'(u.oh));
                chk("update_flags",
                    64'({o_sq_update_retry, o_sq_update_replay, o_sq_update_mhq_retry, o_sq_update_mhq_replay}),
                    64'(u.fl));
            end
        end
    end

    // One cycle of stimulus: drive after the edge, check the retire pulse on the falling edge.
    task automatic cyc(input logic r, input logic [7:0] ret, input logic st, input logic fls,
                       input logic up, input logic [3:0] f, input logic [7:0] ep,
                       input logic [7:0] eu, input string nm);
        @(posedge clk);
        #1;
        rst                     = r;
        i_sq_retirable          = ret;
        i_lsu_stall             = st;
        i_flush                 = fls;
        i_lsu_update_en         = up;
        i_lsu_update_retry      = f[3];
        i_lsu_update_replay     = f[2];
        i_lsu_update_mhq_retry  = f[1];
        i_lsu_update_mhq_replay = f[0];
        if (eu != 8'h00) upd_q.push_back('{oh: eu, fl: f});
        @(negedge clk);
        chk({nm, "_pulse"}, 64'(o_sq_retire_en), 64'(ep));
        for (int i = 0; i < D; i++)
            if (ep[i]) launch_q.push_back(i);
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin
            ent_addr[i] = AW'(32'h80 * i);
            ent_data[i] = DW'(32'hA9 + i);
            ent_tag[i]  = RW'(i + 3);
            ent_op[i]   = OW'(i) ^ OW'(5);
            i_sq_addr[i*AW +: AW] = ent_addr[i];
            i_sq_data[i*DW +: DW] = ent_data[i];
            i_sq_tag[i*RW +: RW]  = ent_tag[i];
            i_sq_op[i*OW +: OW]   = ent_op[i];
        end

        // Reset state
        cyc(1, 8'h00, 0, 0, 0, 4'h0, 8'h00, 8'h00, "rst0");
        cyc(1, 8'h00, 0, 0, 0, 4'h0, 8'h00, 8'h00, "rst1");
        cyc(0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 8'h00, "idle");
        chk("rst_lsu_en",   64'(o_lsu_retire_en), 0);
        chk("rst_lsu_addr", 64'(o_lsu_retire_addr), 0);
        chk("rst_lsu_data", 64'(o_lsu_retire_data), 0);
        chk("rst_full",     64'(o_inflight_full), 0);
        chk("rst_upd_en",   64'(o_sq_update_en), 0);

        // Single launch of entry 2 (addr 0x100, data 0xAB), then retire it
        cyc(0, 8'h04, 0, 0, 0, 4'h0, 8'h04, 8'h00, "s1_l2");
        cyc(0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 8'h00, "s1_idle");
        chk("s1_addr", 64'(o_lsu_retire_addr), 64'h100);
        chk("s1_data", 64'(o_lsu_retire_data), 64'hAB);
        cyc(0, 8'h00, 0, 0, 1, 4'h0, 8'h00, 8'h04, "s1_upd");

        // Round-robin over {0,7} from rr=3: 7, 0, 7 (last with simultaneous pop)
        cyc(0, 8'h81, 0, 0, 0, 4'h0, 8'h80, 8'h00, "s2_a");
        cyc(0, 8'h81, 0, 0, 0, 4'h0, 8'h01, 8'h00, "s2_b");
        cyc(0, 8'h81, 0, 0, 1, 4'h8, 8'h80, 8'h80, "s2_c");
        cyc(0, 8'h00, 0, 0, 1, 4'h2, 8'h00, 8'h01, "s2_d");
        cyc(0, 8'h00, 0, 0, 1, 4'h1, 8'h00, 8'h80, "s2_e");

        // Launch 3 and 5, route replay then clean update, then an update on empty
        cyc(0, 8'h08, 0, 0, 0, 4'h0, 8'h08, 8'h00, "s3_l3");
        cyc(0, 8'h20, 0, 0, 0, 4'h0, 8'h20, 8'h00, "s3_l5");
        cyc(0, 8'h00, 0, 0, 1, 4'h4, 8'h00, 8'h08, "s3_u3");
        cyc(0, 8'h00, 0, 0, 1, 4'h0, 8'h00, 8'h20, "s3_u5");
        cyc(0, 8'h00, 0, 0, 1, 4'h0, 8'h00, 8'h00, "s3_uempty");
        chk("s3_upd_empty", 64'(o_sq_update_en), 0);

        // Fill the tracker (rr=6): 6, 7, 0, 1
        cyc(0, 8'h40, 0, 0, 0, 4'h0, 8'h40, 8'h00, "s4_l6");
        cyc(0, 8'h80, 0, 0, 0, 4'h0, 8'h80, 8'h00, "s4_l7");
        cyc(0, 8'h01, 0, 0, 0, 4'h0, 8'h01, 8'h00, "s4_l0");
        cyc(0, 8'h02, 0, 0, 0, 4'h0, 8'h02, 8'h00, "s4_l1");
        cyc(0, 8'h04, 0, 0, 0, 4'h0, 8'h00, 8'h00, "s4_full_block");
        chk("s4_full", 64'(o_inflight_full), 1);
        cyc(0, 8'h04, 0, 0, 1, 4'h0, 8'h00, 8'h40, "s4_pop_no_launch");
        cyc(0, 8'h04, 0, 0, 0, 4'h0, 8'h04, 8'h00, "s4_launch_after");
        cyc(0, 8'h00, 0, 0, 1, 4'h0, 8'h00, 8'h80, "s4_d1");
        chk("s4_full_again", 64'(o_inflight_full), 1);
        cyc(0, 8'h00, 0, 0, 1, 4'h0, 8'h00, 8'h01, "s4_d2");
        cyc(0, 8'h00, 0, 0, 1, 4'h0, 8'h00, 8'h02, "s4_d3");
        cyc(0, 8'h00, 0, 0, 1, 4'h0, 8'h00, 8'h04, "s4_d4");
        chk("s4_not_full", 64'(o_inflight_full), 0);

        // Flush with two in flight (rr=3): launch 4, 5, flush coincident with update
        cyc(0, 8'h10, 0, 0, 0, 4'h0, 8'h10, 8'h00, "s5_l4");
        cyc(0, 8'h20, 0, 0, 0, 4'h0, 8'h20, 8'h00, "s5_l5");
        cyc(0, 8'h01, 0, 1, 1, 4'h4, 8'h00, 8'h00, "s5_flush");
        chk("s5_flush_upd", 64'(o_sq_update_en), 0);
        cyc(0, 8'h00, 0, 0, 1, 4'h0, 8'h00, 8'h00, "s5_post");
        chk("s5_post_lsu_en", 64'(o_lsu_retire_en), 0);
        chk("s5_post_upd",    64'(o_sq_update_en), 0);
        // rr preserved at 6 across flush: entry 6 wins over entry 0
        cyc(0, 8'h41, 0, 0, 0, 4'h0, 8'h40, 8'h00, "s5_rr_kept");
        cyc(0, 8'h00, 0, 0, 1, 4'h0, 8'h00, 8'h40, "s5_drain");

        // Stall holds off launch; release launches in the same cycle (rr=7)
        cyc(0, 8'h01, 1, 0, 0, 4'h0, 8'h00, 8'h00, "s6_stall0");
        cyc(0, 8'h01, 1, 0, 0, 4'h0, 8'h00, 8'h00, "s6_stall1");
        cyc(0, 8'h01, 1, 0, 0, 4'h0, 8'h00, 8'h00, "s6_stall2");
        cyc(0, 8'h01, 0, 0, 0, 4'h0, 8'h01, 8'h00, "s6_release");
        cyc(0, 8'h00, 0, 0, 1, 4'h0, 8'h00, 8'h01, "s6_drain");

        // Reset mid-operation (rr=1): launch 1, reset, later update ignored, rr back to 0
        cyc(0, 8'h02, 0, 0, 0, 4'h0, 8'h02, 8'h00, "s7_l1");
        cyc(1, 8'h00, 0, 0, 0, 4'h0, 8'h00, 8'h00, "s7_rst");
        cyc(0, 8'h00, 0, 0, 1, 4'h0, 8'h00, 8'h00, "s7_upd_ignored");
        chk("s7_upd", 64'(o_sq_update_en), 0);
        chk("s7_lsu_en", 64'(o_lsu_retire_en), 0);
        cyc(0, 8'h81, 0, 0, 0, 4'h0, 8'h01, 8'h00, "s7_rr_reset");
        cyc(0, 8'h00, 0, 0, 1, 4'h0, 8'h00, 8'h01, "s7_drain");
        cyc(0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 8'h00, "tail0");
        cyc(0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 8'h00, "tail1");

        chk("launch_q_empty", 64'(launch_q.size()), 0);
        chk("upd_q_empty",    64'(upd_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/procyon_lsu_sq_launch.md
Name: procyon_lsu_sq_launch

Overview:
- Initiator side of the SQ-entry retire/update interface.
- Picks one retirable store queue entry per cycle, pulses that entry's retire enable and forwards its op/tag/addr/data to the LSU pipeline.
- Tracks launched entries in order until the LSU returns the retry/replay outcome, then routes that update back to the entry that was launched.
- Sits between the SQ entry array and the LSU store-retire arbitration port.

Parameters:
OPTN_SQ_DEPTH, 8, number of SQ entries (power of 2, >=2)
OPTN_DATA_WIDTH, 32, store data width
OPTN_ADDR_WIDTH, 32, store address width
OPTN_ROB_IDX_WIDTH, 5, ROB tag width
OPTN_MAX_INFLIGHT, 4, max launched stores awaiting an LSU update (power of 2, >=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_flush  in  1  pipeline flush
i_sq_retirable  in  OPTN_SQ_DEPTH  per-entry retirable (NONSPECULATIVE) status
i_sq_op  in  OPTN_SQ_DEPTH*`PCYN_OP_WIDTH  per-entry op, flattened, entry 0 in LSBs
i_sq_tag  in  OPTN_SQ_DEPTH*OPTN_ROB_IDX_WIDTH  per-entry ROB tag, flattened
i_sq_addr  in  OPTN_SQ_DEPTH*OPTN_ADDR_WIDTH  per-entry address, flattened
i_sq_data  in  OPTN_SQ_DEPTH*OPTN_DATA_WIDTH  per-entry data, flattened
o_sq_retire_en  out  OPTN_SQ_DEPTH  one-hot retire pulse to the selected entry
i_lsu_stall  in  1  LSU cannot accept a store this cycle
o_lsu_retire_en  out  1  launched store valid
o_lsu_retire_op  out  `PCYN_OP_WIDTH  launched op
o_lsu_retire_tag  out  OPTN_ROB_IDX_WIDTH  launched tag
o_lsu_retire_addr  out  OPTN_ADDR_WIDTH  launched address
o_lsu_retire_data  out  OPTN_DATA_WIDTH  launched data
i_lsu_update_en  in  1  LSU outcome for the oldest in-flight store
i_lsu_update_retry  in  1  outcome flag, passed through
i_lsu_update_replay  in  1  outcome flag, passed through
i_lsu_update_mhq_retry  in  1  outcome flag, passed through
i_lsu_update_mhq_replay  in  1  outcome flag, passed through
o_sq_update_en  out  OPTN_SQ_DEPTH  one-hot update enable to the owning entry
o_sq_update_retry, o_sq_update_replay, o_sq_update_mhq_retry, o_sq_update_mhq_replay  out  1 each  broadcast outcome flags
o_inflight_full  out  1  in-flight FIFO full

Behaviour:
Reset:
- All registered outputs are 0.
- rr pointer = 0; in-flight FIFO is empty.

Launch condition:
- launch = |i_sq_retirable & !i_lsu_stall & !o_inflight_full & !i_flush.

Selection:
- Round-robin: select the first retirable index at or after rr_ptr, wrapping modulo OPTN_SQ_DEPTH.
- On launch, rr_ptr <= selected+1 (wraps).

Retire pulse and LSU outputs:
- o_sq_retire_en is combinational and one-hot; it is all zero when launch=0. The entry moves to LAUNCHED on the next edge.
- o_lsu_retire_* are registered: valid exactly one cycle after the pulse, holding that entry's fields as sampled in the pulse cycle.
- o_lsu_retire_en = 0 in cycles with no launch.

In-flight FIFO:
- Depth OPTN_MAX_INFLIGHT; each slot holds a log2(OPTN_SQ_DEPTH) entry index.
- Pushed on launch.
- LSU updates return in launch order.

Update routing:
- On i_lsu_update_en with FIFO non-empty: o_sq_update_en = onehot(FIFO head), combinational in the same cycle. Flags are passed through combinationally; head is popped.
- Push and pop in the same cycle are allowed; count is unchanged; a full FIFO may pop and push simultaneously only if the pop is evaluated first. o_inflight_full is computed pre-pop, so a full FIFO does not launch in that cycle.
- i_lsu_update_en with FIFO empty: ignored, no o_sq_update_en asserted.

Flush:
- In the i_flush cycle: no launch, and o_sq_update_en = 0.
- Next edge: FIFO cleared and o_lsu_retire_en cleared (any pending registered launch is dropped).
- Entries return LAUNCHED->NONSPECULATIVE themselves and are relaunched later.
- rr_ptr is preserved.

Reset mid-operation:
- FIFO and output registers are cleared on the same edge; no update is routed afterwards.

Optional Feature:
- Macro: PCYN_SQ_LAUNCH_PERF_CNT_EN.
- When defined, adds output o_perf_launch_cnt [31:0], which increments on each launch, and o_perf_relaunch_cnt [31:0], which increments on each routed update with (retry|replay|mhq_retry|mhq_replay)=1.
- Both counters saturate at 2^32-1 and clear on rst; they are not cleared by flush.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then i_sq_retirable=8'b0000_0100 with entry 2 addr=0x100 data=0xAB -> o_sq_retire_en=8'b0000_0100 in cycle 0; cycle 1 o_lsu_retire_en=1, addr=0x100, data=0xAB.
- Retirable=8'b1000_0001 held, rr_ptr=0, no stall -> launch order entry 0, then 7, then 0; rr_ptr wraps 1->0.
- Launch entries 3 and 5, then i_lsu_update_en with replay=1, then update with all flags 0 -> o_sq_update_en=0x08 with o_sq_update_replay=1, then 0x20; FIFO empty afterwards.
- OPTN_MAX_INFLIGHT=4, four launches with no updates -> o_inflight_full=1, fifth retirable entry gets no pulse; one update plus retirable in the same cycle -> no launch that cycle, launch the next cycle.
- Two launches in flight, i_flush=1 coincident with i_lsu_update_en -> o_sq_update_en=0 and no retire pulse; next cycle FIFO empty and o_lsu_retire_en=0; subsequent i_lsu_update_en is ignored.
- i_lsu_stall=1 with retirable=0x01 for 3 cycles -> no pulse; stall released -> pulse the same cycle and registered launch the next.
